keypad_scan_ctrl: RTL

Scan controller for the 4x3 matrix keypad. Drives one-cold row strobes at a fixed scan rate, samples the active-low column inputs, debounces a single pressed key, and presents each confirmed press as a 4-bit key code on a valid/ready handshake. Sits between the keypad pins and downstream consumers such as the 7-segment display logic and the entry FSM.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_tick_gen.sv | 26 ++
 rtl/keypad_scan_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and key-code mapping for the 4x3 keypad scan controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HOLD
    } scan_state_t;

    // One-cold row strobes, listed in scan order
    localparam logic [3:0] ROW_123 = 4'b1101;
    localparam logic [3:0] ROW_456 = 4'b1011;
    localparam logic [3:0] ROW_789 = 4'b0111;
    localparam logic [3:0] ROW_S0H = 4'b1110;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    localparam logic [2:0] COL_IDLE = 3'b111;

    function automatic logic [3:0] row_pattern(input logic [1:0] idx);
        case (idx)
            2'd0:    return ROW_123;
            2'd1:    return ROW_456;
            2'd2:    return ROW_789;
            default: return ROW_S0H;
        endcase
    endfunction

    function automatic logic single_low(input logic [2:0] col);
        return (col == 3'b110) || (col == 3'b101) || (col == 3'b011);
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] col);
        case (col)
            3'b110:  return 2'd0;
            3'b101:  return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0:    return KEY_STAR;
                2'd1:    return 4'h0;
                default: return KEY_HASH;
            endcase
        end
        return ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
module keypad_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: row strobing, single-key debounce, valid/ready key events.
// Optional auto-repeat is enabled by defining KEYPAD_TYPEMATIC_EN.
module keypad_scan_ctrl #(
    parameter int TICK_DIV       = 50,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 2000,
    parameter int REPEAT_RATE    = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] column,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_overflow
);
    import keypad_pkg::*;

    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    logic        tick;
    scan_state_t state_reg, state_next;
    logic [1:0]  row_idx_reg, row_idx_next;
    logic [2:0]  col_latch_reg, col_latch_next;
    logic [3:0]  deb_cnt_reg, deb_cnt_next;
    logic [3:0]  rel_cnt_reg, rel_cnt_next;
    logic        key_valid_reg, key_valid_next;
    logic [3:0]  key_code_reg, key_code_next;
    logic        key_overflow_reg, key_overflow_next;
    logic        emit;
    logic [3:0]  emit_code;

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic          rep_first_reg, rep_first_next;
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

    keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= SCAN;
            row_idx_reg      <= 2'd0;
            col_latch_reg    <= COL_IDLE;
            deb_cnt_reg      <= '0;
            rel_cnt_reg      <= '0;
            key_valid_reg    <= 1'b0;
            key_code_reg     <= 4'h0;
            key_overflow_reg <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_reg      <= '0;
            rep_first_reg    <= 1'b1;
`endif
        end else begin
            state_reg        <= state_next;
            row_idx_reg      <= row_idx_next;
            col_latch_reg    <= col_latch_next;
            deb_cnt_reg      <= deb_cnt_next;
            rel_cnt_reg      <= rel_cnt_next;
            key_valid_reg    <= key_valid_next;
            key_code_reg     <= key_code_next;
            key_overflow_reg <= key_overflow_next;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_reg      <= rep_cnt_next;
            rep_first_reg    <= rep_first_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_idx_next   = row_idx_reg;
        col_latch_next = col_latch_reg;
        deb_cnt_next   = deb_cnt_reg;
        rel_cnt_next   = rel_cnt_reg;
        emit           = 1'b0;
        emit_code      = key_lookup(row_idx_reg, col_index(col_latch_reg));
`ifdef KEYPAD_TYPEMATIC_EN
        rep_cnt_next   = rep_cnt_reg;
        rep_first_next = rep_first_reg;
`endif
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (single_low(column)) begin
                        col_latch_next = column;
                        deb_cnt_next   = 4'd1;
                        rel_cnt_next   = '0;
                        if (DS == 4'd1) begin
                            emit       = 1'b1;
                            emit_code  = key_lookup(row_idx_reg, col_index(column));
                            state_next = HOLD;
`ifdef KEYPAD_TYPEMATIC_EN
                            rep_cnt_next   = '0;
                            rep_first_next = 1'b1;
`endif
                        end else begin
                            state_next = CONFIRM;
                        end
                    end else begin
                        row_idx_next = row_idx_reg + 2'd1;
                    end
                end
                CONFIRM: begin
                    if (column == col_latch_reg) begin
                        deb_cnt_next = deb_cnt_reg + 4'd1;
                        if (deb_cnt_reg + 4'd1 == DS) begin
                            emit         = 1'b1;
                            state_next   = HOLD;
                            rel_cnt_next = '0;
`ifdef KEYPAD_TYPEMATIC_EN
                            rep_cnt_next   = '0;
                            rep_first_next = 1'b1;
`endif
                        end
                    end else begin
                        state_next   = SCAN;
                        row_idx_next = row_idx_reg + 2'd1;
                    end
                end
                HOLD: begin
                    if (column == COL_IDLE) begin
`ifdef KEYPAD_TYPEMATIC_EN
                        rep_cnt_next = '0;
`endif
                        if (rel_cnt_reg + 4'd1 == DS) begin
                            state_next   = SCAN;
                            row_idx_next = row_idx_reg + 2'd1;
                            rel_cnt_next = '0;
                        end else begin
                            rel_cnt_next = rel_cnt_reg + 4'd1;
                        end
                    end else begin
                        rel_cnt_next = '0;
`ifdef KEYPAD_TYPEMATIC_EN
                        // Any latched bit going high restarts the repeat interval
                        if (column != col_latch_reg) begin
                            rep_cnt_next = '0;
                        end else if (rep_first_reg ? (rep_cnt_reg + RW'(1) == RW'(REPEAT_DELAY))
                                                   : (rep_cnt_reg + RW'(1) == RW'(REPEAT_RATE))) begin
                            emit           = 1'b1;
                            rep_cnt_next   = '0;
                            rep_first_next = 1'b0;
                        end else begin
                            rep_cnt_next = rep_cnt_reg + RW'(1);
                        end
`endif
                    end
                end
                default: state_next = SCAN;
            endcase
        end

        // A transfer in the same cycle frees the slot for the new event
        key_valid_next    = key_valid_reg & ~key_ready;
        key_code_next     = key_code_reg;
        key_overflow_next = 1'b0;
        if (emit) begin
            if (!key_valid_reg || key_ready) begin
                key_valid_next = 1'b1;
                key_code_next  = emit_code;
            end else begin
                key_overflow_next = 1'b1;
            end
        end
    end

    assign row          = row_pattern(row_idx_reg);
    assign key_valid    = key_valid_reg;
    assign key_code     = key_code_reg;
    assign key_overflow = key_overflow_reg;

endmodule
